// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback, and aborts memory waits that exceed TIMEOUT_CYCLES.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        old_pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ALUop,
  output logic [1:0]  pc_source,
  output logic        retire,
  output logic        illegal,
  output logic        bus_error,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_waitState;
  logic             w_timeout;
  logic             w_pcWrite;
  logic             w_pcWriteCond;
  logic             w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_unused = &{1'b0, instr[31:15], instr[11:7]};

  assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_waitState && !mem_ready &&
                       (r_wait == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_DECODE: begin
        case (w_opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011: w_next = (w_funct3 == 3'b000 || w_funct3 == 3'b110 || w_funct3 == 3'b011)
                               ? S_EXEC_R : S_ILLEGAL;
          7'b0010011: w_next = (w_funct3 == 3'b000 || w_funct3 == 3'b010 || w_funct3 == 3'b110)
                               ? S_EXEC_I : S_ILLEGAL;
          7'b1100011: w_next = (w_funct3 == 3'b000) ? S_BRANCH : S_ILLEGAL;
          default:    w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: w_next = instr[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || w_timeout) w_next = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALUWB;
      default:            w_next = S_FETCH;
    endcase
  end

  // The wait counter restarts on every entry to a memory-wait state, including a
  // timeout that re-enters FETCH from FETCH, and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next == S_FETCH || w_next == S_MEMRD || w_next == S_MEMWR) &&
          (w_next != r_state || w_timeout))
        r_wait <= '0;
      else if (w_waitState && !mem_ready && r_wait != {CNT_W{1'b1}})
        r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    ir_write      = 1'b0;
    old_pc_write  = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    ALUop         = 2'b00;
    pc_source     = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    bus_error     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read     = 1'b1;
          alu_src_b    = 2'b01;
          ir_write     = mem_ready;
          old_pc_write = mem_ready;
          w_pcWrite    = mem_ready;
          bus_error    = w_timeout;
        end
        S_DECODE: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEMADR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read  = 1'b1;
          i_or_d    = 1'b1;
          bus_error = w_timeout;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
          bus_error = w_timeout;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b01;
          ALUop     = 2'b11;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          ALUop     = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b01;
          ALUop         = 2'b01;
          w_pcWriteCond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
        end
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_en   = w_pcWrite | (w_pcWriteCond & zero);
  assign state_o = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues its hand-computed
// expected output vector, and a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, ir_write, old_pc_write, i_or_d, mem_read, mem_write;
  logic        reg_write, mem_to_reg, retire, illegal, bus_error;
  logic [1:0]  alu_src_a, alu_src_b, ALUop, pc_source;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .old_pc_write(old_pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUop(ALUop), .pc_source(pc_source), .retire(retire), .illegal(illegal),
    .bus_error(bus_error), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Vector layout: state_o, {pc_en,ir_write,old_pc_write,i_or_d,mem_read,mem_write,
  // reg_write,mem_to_reg}, alu_src_a, alu_src_b, ALUop, pc_source, {retire,illegal,bus_error}
  localparam logic [22:0] E_RESET      = {4'd0,  8'b00000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_FETCH_RDY  = {4'd0,  8'b11101000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_FETCH_WAIT = {4'd0,  8'b00001000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_FETCH_TO   = {4'd0,  8'b00001000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b001};
  localparam logic [22:0] E_DECODE     = {4'd1,  8'b00000000, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_MEMADR     = {4'd2,  8'b00000000, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_MEMRD      = {4'd3,  8'b00011000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_MEMWB      = {4'd4,  8'b00000011, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [22:0] E_MEMWR_WAIT = {4'd5,  8'b00010100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [22:0] E_MEMWR_RDY  = {4'd5,  8'b00010100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [22:0] E_MEMWR_TO   = {4'd5,  8'b00010100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001};
  localparam logic [22:0] E_EXEC_R     = {4'd6,  8'b00000000, 2'b01, 2'b00, 2'b11, 2'b00, 3'b000};
  localparam logic [22:0] E_EXEC_I     = {4'd7,  8'b00000000, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000};
  localparam logic [22:0] E_ALUWB      = {4'd8,  8'b00000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [22:0] E_BR_TAKEN   = {4'd9,  8'b10000000, 2'b01, 2'b00, 2'b01, 2'b01, 3'b100};
  localparam logic [22:0] E_BR_NOT     = {4'd9,  8'b00000000, 2'b01, 2'b00, 2'b01, 2'b01, 3'b100};
  localparam logic [22:0] E_ILLEGAL    = {4'd10, 8'b00000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010};

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] SW   = 32'h0020A223;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] BADOP = 32'h0000007F;
  localparam logic [31:0] BADR = 32'h00001033;

  typedef struct {
    logic [22:0] exp;
    string       name;
  } sbItem_t;

  sbItem_t sb[$];

  logic [22:0] obs;
  assign obs = {state_o, pc_en, ir_write, old_pc_write, i_or_d, mem_read, mem_write,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, ALUop, pc_source,
                retire, illegal, bus_error};

  // One cycle of stimulus: drive inputs just after the rising edge and queue what the
  // DUT must show for that cycle.
  task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic z,
                               input logic mr, input logic [22:0] exp, input string name);
    sbItem_t it;
    @(posedge clk);
    #1;
    rst       = r;
    instr     = ins;
    zero      = z;
    mem_ready = mr;
    it.exp    = exp;
    it.name   = name;
    sb.push_back(it);
  endtask

  task automatic checkOutput(input sbItem_t it);
    checks++;
    if (obs !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b", it.name, obs, it.exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    applyStimulus(1, ADDI, 0, 1, E_RESET, "reset0");
    applyStimulus(1, ADDI, 0, 1, E_RESET, "reset1");

    applyStimulus(0, ADDI, 0, 1, E_FETCH_RDY, "addi_fetch");
    applyStimulus(0, ADDI, 0, 1, E_DECODE,    "addi_decode");
    applyStimulus(0, ADDI, 0, 1, E_EXEC_I,    "addi_exec");
    applyStimulus(0, ADDI, 0, 1, E_ALUWB,     "addi_wb");

    applyStimulus(0, LW, 0, 0, E_FETCH_WAIT, "lw_fetch_wait");
    applyStimulus(0, LW, 0, 1, E_FETCH_RDY,  "lw_fetch");
    applyStimulus(0, LW, 0, 1, E_DECODE,     "lw_decode");
    applyStimulus(0, LW, 0, 1, E_MEMADR,     "lw_memadr");
    for (int i = 0; i < 3; i++) applyStimulus(0, LW, 0, 0, E_MEMRD, "lw_memrd_wait");
    applyStimulus(0, LW, 0, 1, E_MEMRD,      "lw_memrd_rdy");
    applyStimulus(0, LW, 0, 1, E_MEMWB,      "lw_memwb");

    applyStimulus(0, BEQ, 1, 1, E_FETCH_RDY, "beq_t_fetch");
    applyStimulus(0, BEQ, 1, 1, E_DECODE,    "beq_t_decode");
    applyStimulus(0, BEQ, 1, 1, E_BR_TAKEN,  "beq_taken");
    applyStimulus(0, BEQ, 0, 1, E_FETCH_RDY, "beq_n_fetch");
    applyStimulus(0, BEQ, 0, 1, E_DECODE,    "beq_n_decode");
    applyStimulus(0, BEQ, 0, 1, E_BR_NOT,    "beq_not_taken");

    applyStimulus(0, ADD, 0, 1, E_FETCH_RDY, "add_fetch");
    applyStimulus(0, ADD, 0, 1, E_DECODE,    "add_decode");
    applyStimulus(0, ADD, 0, 1, E_EXEC_R,    "add_exec");
    applyStimulus(0, ADD, 0, 1, E_ALUWB,     "add_wb");

    applyStimulus(0, BADOP, 0, 1, E_FETCH_RDY, "badop_fetch");
    applyStimulus(0, BADOP, 0, 1, E_DECODE,    "badop_decode");
    applyStimulus(0, BADOP, 0, 1, E_ILLEGAL,   "badop_illegal");
    applyStimulus(0, BADR,  0, 1, E_FETCH_RDY, "badr_fetch");
    applyStimulus(0, BADR,  0, 1, E_DECODE,    "badr_decode");
    applyStimulus(0, BADR,  0, 1, E_ILLEGAL,   "badr_illegal");

    applyStimulus(0, SW, 0, 1, E_FETCH_RDY, "sw_to_fetch");
    applyStimulus(0, SW, 0, 1, E_DECODE,    "sw_to_decode");
    applyStimulus(0, SW, 0, 1, E_MEMADR,    "sw_to_memadr");
    for (int i = 0; i < 4; i++) applyStimulus(0, SW, 0, 0, E_MEMWR_WAIT, "sw_to_wait");
    applyStimulus(0, SW, 0, 0, E_MEMWR_TO,  "sw_timeout");

    applyStimulus(0, SW, 0, 1, E_FETCH_RDY, "sw_edge_fetch");
    applyStimulus(0, SW, 0, 1, E_DECODE,    "sw_edge_decode");
    applyStimulus(0, SW, 0, 1, E_MEMADR,    "sw_edge_memadr");
    for (int i = 0; i < 4; i++) applyStimulus(0, SW, 0, 0, E_MEMWR_WAIT, "sw_edge_wait");
    applyStimulus(0, SW, 0, 1, E_MEMWR_RDY, "sw_edge_ready_wins");

    for (int i = 0; i < 4; i++) applyStimulus(0, ADDI, 0, 0, E_FETCH_WAIT, "fetch_to_wait");
    applyStimulus(0, ADDI, 0, 0, E_FETCH_TO,  "fetch_timeout");
    applyStimulus(0, LW, 0, 1, E_FETCH_RDY,   "lw2_fetch");
    applyStimulus(0, LW, 0, 1, E_DECODE,      "lw2_decode");
    applyStimulus(0, LW, 0, 1, E_MEMADR,      "lw2_memadr");
    applyStimulus(1, LW, 0, 0, E_RESET,       "midinstr_reset");
    applyStimulus(0, ADDI, 0, 1, E_FETCH_RDY, "post_reset_fetch");
    applyStimulus(0, ADDI, 0, 1, E_DECODE,    "post_reset_decode");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
